// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the LUT neuron array: address width helper,
// address-width limit check and default word typedefs.
package lut_neuron_pkg;

  localparam int IN_BITS_DEF  = 2;
  localparam int FAN_IN_DEF   = 4;
  localparam int OUT_BITS_DEF = 2;
  localparam int MAX_ADDR_W   = 12;

  // Table address width: all fan-in activations concatenated.
  function automatic int addr_w(input int in_bits, input int fan_in);
    return in_bits * fan_in;
  endfunction

  // A table deeper than 2^12 entries is not a sensible distributed RAM.
  function automatic bit addr_w_ok(input int in_bits, input int fan_in);
    return (addr_w(in_bits, fan_in) >= 1) && (addr_w(in_bits, fan_in) <= MAX_ADDR_W);
  endfunction

  localparam int ADDR_W_DEF = addr_w(IN_BITS_DEF, FAN_IN_DEF);

  typedef logic [ADDR_W_DEF-1:0]   addr_t;
  typedef logic [OUT_BITS_DEF-1:0] out_t;

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: 2^ADDR_W x OUT_BITS distributed RAM with a
// single synchronous write port and an asynchronous read port. The async
// read means a lookup in the same cycle as a write sees the old entry.
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [OUT_BITS-1:0] mem_r [DEPTH];

  // Table write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/lut_neuron_array.sv
// Array of NUM_NEURONS LUT neurons with run-time loadable tables.
// Two-stage pipeline: S1 captures the address vector, S2 registers the
// looked-up outputs. Valid/ready on both sides, full rate when unstalled.
module lut_neuron_array
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS     = IN_BITS_DEF,
  parameter int FAN_IN      = FAN_IN_DEF,
  parameter int OUT_BITS    = OUT_BITS_DEF,
  parameter int NUM_NEURONS = 4,
  parameter int NEUR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int ADDR_W     = addr_w(IN_BITS, FAN_IN)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [NEUR_W-1:0]               cfg_neuron,
  input  logic [ADDR_W-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data
);

  if (!addr_w_ok(IN_BITS, FAN_IN)) begin : g_bad_addr_w
    $error("lut_neuron_array: IN_BITS*FAN_IN must be between 1 and 12");
  end

  logic                            v1_r;
  logic                            v2_r;
  logic [NUM_NEURONS*ADDR_W-1:0]   s1_addr_r;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data_r;
  logic [NUM_NEURONS*OUT_BITS-1:0] lut_rd_s;
  logic [NUM_NEURONS-1:0]          tbl_we_s;
  logic                            adv1_s;
  logic                            adv2_s;

  // S2 can move when empty or drained; S1 can move when empty or S2 moves.
  assign adv2_s   = !v2_r || out_ready;
  assign adv1_s   = !v1_r || adv2_s;
  // A table write cycle never accepts a new beat.
  assign in_ready = adv1_s && !cfg_we;

  assign out_valid = v2_r;
  assign out_data  = out_data_r;

  // Decode the table write strobe; out-of-range neuron indices hit nothing.
  always_comb begin
    tbl_we_s = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (cfg_we && (int'(cfg_neuron) == n)) begin
        tbl_we_s[n] = 1'b1;
      end else begin
        tbl_we_s[n] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
    lut_neuron_table #(
      .ADDR_W   (ADDR_W),
      .OUT_BITS (OUT_BITS)
    ) u_table (
      .clk   (clk),
      .we    (tbl_we_s[g]),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (s1_addr_r[g*ADDR_W +: ADDR_W]),
      .rdata (lut_rd_s[g*OUT_BITS +: OUT_BITS])
    );
  end

  // Stage 1: capture the address vector of an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      s1_addr_r <= '0;
    end else if (adv1_s) begin
      v1_r      <= in_valid && in_ready;
      s1_addr_r <= in_data;
    end else begin
      v1_r      <= v1_r;
      s1_addr_r <= s1_addr_r;
    end
  end

  // Stage 2: register table outputs; hold while stalled downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r       <= 1'b0;
      out_data_r <= '0;
    end else if (adv2_s) begin
      if (v1_r) begin
        v2_r       <= 1'b1;
        out_data_r <= lut_rd_s;
      end else begin
        v2_r       <= 1'b0;
        out_data_r <= out_data_r;
      end
    end else begin
      v2_r       <= v2_r;
      out_data_r <= out_data_r;
    end
  end

endmodule
